// File: rtl/mypio_avs_regs.sv
// rtl/mypio_avs_regs.sv - Avalon-MM register responder for mypio_0: LEDs, 7-seg scan, debounced inputs, edge IRQ
// Synchronises and debounces switch/key, captures edges into a W1C register and raises a maskable level IRQ.
module mypio_avs_regs #(
   parameter int SCAN_DIV  = 50000,
   parameter int DB_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        irq,
   output logic [7:0]  led,
   output logic [7:0]  pattern_keys,
   output logic [7:0]  user_keys,
   output logic [11:0] seg_output,
   input  logic [3:0]  switch,
   input  logic [1:0]  key
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [2:0] A_LED     = 3'd0;
   localparam logic [2:0] A_SEGDATA = 3'd1;
   localparam logic [2:0] A_PATTERN = 3'd2;
   localparam logic [2:0] A_USER    = 3'd3;
   localparam logic [2:0] A_INPUT   = 3'd4;
   localparam logic [2:0] A_EDGE    = 3'd5;
   localparam logic [2:0] A_MASK    = 3'd6;
   localparam logic [2:0] A_SEGCTRL = 3'd7;

   // Idle level of the inputs: switches low, keys released (high).
   localparam logic [5:0] IN_IDLE = 6'b110000;

   logic [7:0]    led_r;
   logic [15:0]   segdata_r;
   logic [7:0]    pattern_r;
   logic [7:0]    user_r;
   logic [5:0]    edge_flags;
   logic [5:0]    mask_r;
   logic [4:0]    segctrl_r;

   logic [5:0]    sync1;
   logic [5:0]    sync2;
   logic [DW-1:0] db_cnt;
   logic          db_tick;
   logic          db_primed;
   logic [5:0]    db_samp;
   logic [5:0]    db_val;
   logic [5:0]    db_next;
   logic [5:0]    db_agree;
   logic [5:0]    edge_set;
   logic [5:0]    edge_clr;

   logic [SW-1:0] scan_cnt;
   logic          scan_last;
   logic [1:0]    digit_idx;
   logic [3:0]    nibble;
   logic [7:0]    seg_code;
   logic [3:0]    anodes;

   logic [31:0]   rd_mux;
   logic          wr_led;
   logic          wr_segdata;
   logic          wr_pattern;
   logic          wr_user;
   logic          wr_edge;
   logic          wr_mask;
   logic          wr_segctrl;
   logic          unused_bits;

   assign unused_bits = ^avs_writedata[31:16];

   assign wr_led     = avs_write && (avs_address == A_LED);
   assign wr_segdata = avs_write && (avs_address == A_SEGDATA);
   assign wr_pattern = avs_write && (avs_address == A_PATTERN);
   assign wr_user    = avs_write && (avs_address == A_USER);
   assign wr_edge    = avs_write && (avs_address == A_EDGE);
   assign wr_mask    = avs_write && (avs_address == A_MASK);
   assign wr_segctrl = avs_write && (avs_address == A_SEGCTRL);

   assign led          = led_r;
   assign pattern_keys = pattern_r;
   assign user_keys    = user_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_r     <= 8'h00;
         segdata_r <= 16'h0000;
         pattern_r <= 8'h00;
         user_r    <= 8'h00;
         mask_r    <= 6'h00;
         segctrl_r <= 5'h0F;
      end else begin
         if (wr_led)     led_r     <= avs_writedata[7:0];
         if (wr_segdata) segdata_r <= avs_writedata[15:0];
         if (wr_pattern) pattern_r <= avs_writedata[7:0];
         if (wr_user)    user_r    <= avs_writedata[7:0];
         if (wr_mask)    mask_r    <= avs_writedata[5:0];
         if (wr_segctrl) segctrl_r <= avs_writedata[4:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= IN_IDLE;
         sync2 <= IN_IDLE;
      end else begin
         sync1 <= {key, switch};
         sync2 <= sync1;
      end
   end

   assign db_tick = (db_cnt == DW'(DB_CYCLES - 1));

   // A bit follows the synchroniser only when this tick agrees with the previous tick's sample.
   assign db_agree = ~(sync2 ^ db_samp);
   assign db_next  = (db_val & ~db_agree) | (sync2 & db_agree);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt    <= '0;
         db_primed <= 1'b0;
         db_samp   <= IN_IDLE;
         db_val    <= IN_IDLE;
      end else begin
         db_cnt <= db_tick ? '0 : db_cnt + 1'b1;
         if (db_tick) begin
            db_samp   <= sync2;
            db_primed <= 1'b1;
            db_val    <= db_primed ? db_next : sync2;
         end
      end
   end

   always_comb begin
      edge_set = 6'h00;
      if (db_tick && db_primed) begin
         edge_set[3:0] = db_val[3:0] ^ db_next[3:0];
         edge_set[5:4] = db_val[5:4] & ~db_next[5:4];
      end
   end

   assign edge_clr = wr_edge ? avs_writedata[5:0] : 6'h00;

   // Clear is applied before set so a simultaneous capture survives the W1C.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_flags <= 6'h00;
         irq        <= 1'b0;
      end else begin
         edge_flags <= (edge_flags & ~edge_clr) | edge_set;
         irq        <= |(edge_flags & mask_r);
      end
   end

   always_comb begin
      rd_mux = 32'h0;
      case (avs_address)
         A_LED:     rd_mux = {24'h0, led_r};
         A_SEGDATA: rd_mux = {16'h0, segdata_r};
         A_PATTERN: rd_mux = {24'h0, pattern_r};
         A_USER:    rd_mux = {24'h0, user_r};
         A_INPUT:   rd_mux = {26'h0, db_val};
         A_EDGE:    rd_mux = {26'h0, edge_flags};
         A_MASK:    rd_mux = {26'h0, mask_r};
         A_SEGCTRL: rd_mux = {27'h0, segctrl_r};
         default:   rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avs_readdata <= 32'h0;
      end else if (avs_read) begin
         avs_readdata <= rd_mux;
      end
   end

   assign scan_last = (scan_cnt == SW'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt  <= '0;
         digit_idx <= 2'd0;
      end else begin
         scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
         if (scan_last) digit_idx <= digit_idx + 2'd1;
      end
   end

   assign nibble = segdata_r[{digit_idx, 2'b00} +: 4];

   always_comb begin
      seg_code = 8'hFF;
      case (nibble)
         4'h0: seg_code = 8'hC0;
         4'h1: seg_code = 8'hF9;
         4'h2: seg_code = 8'hA4;
         4'h3: seg_code = 8'hB0;
         4'h4: seg_code = 8'h99;
         4'h5: seg_code = 8'h92;
         4'h6: seg_code = 8'h82;
         4'h7: seg_code = 8'hF8;
         4'h8: seg_code = 8'h80;
         4'h9: seg_code = 8'h90;
         4'hA: seg_code = 8'h88;
         4'hB: seg_code = 8'h83;
         4'hC: seg_code = 8'hC6;
         4'hD: seg_code = 8'hA1;
         4'hE: seg_code = 8'h86;
         4'hF: seg_code = 8'h8E;
         default: seg_code = 8'hFF;
      endcase
   end

   always_comb begin
      anodes = 4'hF;
      if (segctrl_r[digit_idx] && !segctrl_r[4]) begin
         anodes = ~(4'b0001 << digit_idx);
      end
   end

   // Anodes and segments load together once per slot, so data changes mid-slot never glitch a digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_output <= 12'hFFF;
      end else if (scan_cnt == '0) begin
         seg_output <= {anodes, seg_code};
      end
   end

endmodule

// File: tb/tb_mypio_avs_regs.sv
// tb/tb_mypio_avs_regs.sv - Self-checking bench for mypio_avs_regs against a behavioural model
// Model tracks registers, debounce ticks and scan slots from the cycle count since reset.
module tb_mypio_avs_regs;

   localparam int SCAN = 4;
   localparam int DB   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        irq;
   logic [7:0]  led;
   logic [7:0]  pattern_keys;
   logic [7:0]  user_keys;
   logic [11:0] seg_output;
   logic [3:0]  switch;
   logic [1:0]  key;

   int total = 0;
   int bad   = 0;

   mypio_avs_regs #(.SCAN_DIV(SCAN), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(rst),
      .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
      .avs_write(avs_write), .avs_writedata(avs_writedata),
      .irq(irq), .led(led), .pattern_keys(pattern_keys), .user_keys(user_keys),
      .seg_output(seg_output), .switch(switch), .key(key)
   );

   always #5 clk = ~clk;

   logic [7:0]  seg_tab [16];
   int          m_n;
   logic        m_primed;
   logic [5:0]  m_raw1, m_raw2, m_samp, m_db, m_edge, m_mask, m_sy, m_nxt, m_set, m_clr;
   logic [7:0]  m_led, m_pat, m_user;
   logic [15:0] m_segdata;
   logic [4:0]  m_segctrl;
   logic        m_irq;
   logic [11:0] m_seg;
   logic [31:0] m_rd;
   logic [3:0]  m_an;
   int          m_idx;

   function automatic logic [31:0] model_reg(input logic [2:0] a);
      case (a)
         3'd0: return {24'h0, m_led};
         3'd1: return {16'h0, m_segdata};
         3'd2: return {24'h0, m_pat};
         3'd3: return {24'h0, m_user};
         3'd4: return {26'h0, m_db};
         3'd5: return {26'h0, m_edge};
         3'd6: return {26'h0, m_mask};
         default: return {27'h0, m_segctrl};
      endcase
   endfunction

   // Reference: edge n after reset; debounce ticks at n%DB==0, slots start at (n-1)%SCAN==0.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n = 0; m_primed = 1'b0;
         m_raw1 = 6'b110000; m_raw2 = 6'b110000; m_samp = 6'b110000; m_db = 6'b110000;
         m_edge = 0; m_mask = 0; m_led = 0; m_pat = 0; m_user = 0; m_segdata = 0;
         m_segctrl = 5'h0F; m_irq = 0; m_seg = 12'hFFF; m_rd = 0;
      end else begin
         m_n = m_n + 1;
         if (avs_read) m_rd = model_reg(avs_address);
         m_sy = m_raw2;
         m_raw2 = m_raw1;
         m_raw1 = {key, switch};
         m_set = 0;
         if (m_n % DB == 0) begin
            if (!m_primed) begin
               m_nxt = m_sy;
               m_primed = 1'b1;
            end else begin
               for (int i = 0; i < 6; i++) m_nxt[i] = (m_sy[i] == m_samp[i]) ? m_sy[i] : m_db[i];
               for (int i = 0; i < 4; i++) if (m_nxt[i] != m_db[i]) m_set[i] = 1'b1;
               for (int j = 4; j < 6; j++) if (m_db[j] && !m_nxt[j]) m_set[j] = 1'b1;
            end
            m_samp = m_sy;
            m_db = m_nxt;
         end
         m_irq = |(m_edge & m_mask);
         if ((m_n - 1) % SCAN == 0) begin
            m_idx = ((m_n - 1) / SCAN) % 4;
            m_an = (m_segctrl[m_idx] && !m_segctrl[4]) ? (4'hF & ~(4'b0001 << m_idx)) : 4'hF;
            m_seg = {m_an, seg_tab[(m_segdata >> (4 * m_idx)) & 16'hF]};
         end
         m_clr = 0;
         if (avs_write) begin
            case (avs_address)
               3'd0: m_led = avs_writedata[7:0];
               3'd1: m_segdata = avs_writedata[15:0];
               3'd2: m_pat = avs_writedata[7:0];
               3'd3: m_user = avs_writedata[7:0];
               3'd5: m_clr = avs_writedata[5:0];
               3'd6: m_mask = avs_writedata[5:0];
               3'd7: m_segctrl = avs_writedata[4:0];
               default: ;
            endcase
         end
         m_edge = (m_edge & ~m_clr) | m_set;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      check("seg", {20'h0, seg_output}, {20'h0, m_seg});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_write = 1'b1; avs_address = a; avs_writedata = d;
      step();
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      avs_read = 1'b1; avs_address = a;
      step();
      avs_read = 1'b0;
      check("rdata_model", avs_readdata, m_rd);
      d = avs_readdata;
   endtask

   logic [31:0] rd;
   logic [11:0] seq [4];
   logic        found;
   int          hold;

   initial begin
      seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
      seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
      seg_tab[8] = 8'h80; seg_tab[9] = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
      seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
      rst = 1'b1; avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
      switch = 4'h0; key = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", avs_readdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_led", {24'h0, led}, 32'h0);
      check("rst_pat", {24'h0, pattern_keys}, 32'h0);
      check("rst_user", {24'h0, user_keys}, 32'h0);
      check("rst_seg", {20'h0, seg_output}, 32'hFFF);
      rst = 1'b0;

      bus_read(3'd4, rd);
      check("input_pre_tick", rd, 32'h30);
      bus_write(3'd0, 32'hA5);
      bus_write(3'd2, 32'h3C);
      bus_write(3'd3, 32'h5A);
      check("led", {24'h0, led}, 32'hA5);
      check("pattern", {24'h0, pattern_keys}, 32'h3C);
      check("user", {24'h0, user_keys}, 32'h5A);
      bus_read(3'd0, rd);
      check("rd_led", rd, 32'hA5);
      bus_read(3'd2, rd);
      check("rd_pattern", rd, 32'h3C);
      avs_read = 1'b1; avs_write = 1'b1; avs_address = 3'd0; avs_writedata = 32'h11;
      step();
      avs_read = 1'b0; avs_write = 1'b0;
      check("rd_pre_write", avs_readdata, 32'hA5);
      check("led_after_rw", {24'h0, led}, 32'h11);

      bus_write(3'd1, 32'h1320);
      bus_write(3'd7, 32'h0F);
      seq[0] = 12'hEC0; seq[1] = 12'hDA4; seq[2] = 12'hBB0; seq[3] = 12'h7F9;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (seg_output == 12'hDA4) found = 1'b1;
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (seg_output == 12'hEC0) found = 1'b1;
      end
      check("seg_sync", {31'h0, found}, 32'h1);
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < SCAN; c++) begin
            if (!(d == 0 && c == 0)) step();
            check("seg_seq", {20'h0, seg_output}, {20'h0, seq[d]});
         end
      end
      bus_write(3'd7, 32'h10);
      steps(2 * SCAN + 1);
      check("seg_blank", {28'h0, seg_output[11:8]}, 32'hF);
      bus_write(3'd7, 32'h0F);

      bus_write(3'd5, 32'h3F);
      for (int i = 0; i < 10; i++) begin
         key[0] = 1'($urandom_range(0, 1));
         step();
      end
      key[0] = 1'b0;
      steps(40);
      bus_read(3'd4, rd);
      check("input_key", rd & 32'h30, 32'h20);
      bus_read(3'd5, rd);
      check("edge_key", rd, 32'h10);
      check("irq_masked", {31'h0, irq}, 32'h0);
      bus_write(3'd6, 32'h10);
      check("irq_lat0", {31'h0, irq}, 32'h0);
      step();
      check("irq_set", {31'h0, irq}, 32'h1);
      bus_write(3'd5, 32'h10);
      step();
      check("irq_clr", {31'h0, irq}, 32'h0);

      key[0] = 1'b1;
      steps(40);
      bus_read(3'd5, rd);
      check("edge_release", rd, 32'h0);
      switch = 4'h5;
      steps(40);
      bus_read(3'd5, rd);
      check("edge_sw", rd, 32'h05);
      bus_write(3'd5, 32'h3F);

      switch[2] = 1'b0;
      step();
      switch[2] = 1'b1;
      steps(30);
      bus_read(3'd4, rd);
      check("input_glitch", rd, 32'h35);
      bus_read(3'd5, rd);
      check("edge_glitch", rd, 32'h0);

      switch[0] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (((m_n + 1) % DB == 0) && m_primed && (m_raw2[0] == m_samp[0]) && (m_raw2[0] != m_db[0])) begin
            bus_write(3'd5, 32'h01);
            found = 1'b1;
         end else begin
            step();
         end
      end
      check("w1c_found", {31'h0, found}, 32'h1);
      bus_read(3'd5, rd);
      check("w1c_set_wins", rd & 32'h1, 32'h1);

      switch = 4'hB; key = 2'b00;
      steps(40);
      bus_read(3'd5, rd);
      check("edge_all", rd, 32'h3F);
      bus_write(3'd6, 32'h3F);
      steps(2);
      check("irq_all", {31'h0, irq}, 32'h1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("mid_rst_seg", {20'h0, seg_output}, 32'hFFF);
      check("mid_rst_irq", {31'h0, irq}, 32'h0);
      check("mid_rst_led", {24'h0, led}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      steps(30);
      bus_read(3'd5, rd);
      check("edge_after_rst", rd, 32'h0);
      bus_read(3'd4, rd);
      check("input_after_rst", rd, 32'h0B);

      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            switch = 4'($urandom);
            key = 2'($urandom);
            hold = $urandom_range(1, 30);
         end
         hold--;
         avs_address = 3'($urandom);
         avs_read = ($urandom_range(0, 3) == 0);
         avs_write = ($urandom_range(0, 3) == 0);
         avs_writedata = $urandom;
         step();
         if (avs_read) check("rand_rdata", avs_readdata, m_rd);
         avs_read = 1'b0;
         avs_write = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
